icosoc_mod_keyscan: RTL

ICOSOC_MOD_KEYSCAN -- requirements
Module: icosoc_mod_keyscan

---
 rtl/icosoc_mod_keyscan.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/icosoc_mod_keyscan.sv
// icosoc_mod_keyscan: 4x4 keypad matrix scanner with per-key debounce and an
// event FIFO behind a simple register bus.
//   clk, resetn        : clock, synchronous active-low reset
//   ctrl_wr/rd/addr    : bus request (byte strobes, read, address[3:2] decoded)
//   ctrl_wdat          : write data (CTRL: bit0 clear overflow, bit1 flush FIFO)
//   ctrl_rdat/done     : registered read data and one-cycle completion pulse
//   col_n              : active-low one-hot column drive
//   row_n              : active-low row sense (asynchronous)
module icosoc_mod_keyscan #(
    parameter int unsigned CLOCK_FREQ_HZ  = 20000000,
    parameter int unsigned SCAN_HZ        = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  ctrl_wr,
    input  logic        ctrl_rd,
    input  logic [15:0] ctrl_addr,
    input  logic [31:0] ctrl_wdat,
    output logic [31:0] ctrl_rdat,
    output logic        ctrl_done,
    output logic [3:0]  col_n,
    input  logic [3:0]  row_n
);

    localparam int unsigned COL_PERIOD  = CLOCK_FREQ_HZ / (4 * SCAN_HZ);
    localparam int unsigned SETTLE_CLKS = COL_PERIOD - 5;
    localparam int unsigned SCW         = (SETTLE_CLKS > 1) ? $clog2(SETTLE_CLKS) : 1;
    localparam int unsigned FIFO_DEPTH  = 8;

    // Elaboration-time parameter range checks
    if (COL_PERIOD < 8) begin : g_bad_period
        $error("icosoc_mod_keyscan: column period must be at least 8 clocks");
    end
    if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_debounce
        $error("icosoc_mod_keyscan: DEBOUNCE_SCANS must be 1..15");
    end

    typedef enum logic [2:0] {
        ST_SETTLE, ST_SAMPLE, ST_PROC0, ST_PROC1, ST_PROC2, ST_PROC3
    } state_e;

    state_e           state_q;
    logic [SCW-1:0]   settle_cnt_q;
    logic [1:0]       col_q;
    logic [3:0]       col_n_q;
    logic [3:0]       sample_q;
    logic [3:0]       row_meta_q;
    logic [3:0]       row_sync_q;
    logic [15:0]      deb_state_q;
    logic [3:0]       deb_cnt_q [16];

    logic [4:0]       fifo_mem_q [FIFO_DEPTH];
    logic [2:0]       wr_ptr_q;
    logic [2:0]       rd_ptr_q;
    logic [3:0]       fifo_count_q;
    logic             ovf_q;
    logic             ctrl_done_q;
    logic [31:0]      ctrl_rdat_q;

    logic             unused_bits;
    assign unused_bits = ^{ctrl_addr[15:4], ctrl_addr[1:0], ctrl_wdat[31:2]};

    assign col_n     = col_n_q;
    assign ctrl_done = ctrl_done_q;
    assign ctrl_rdat = ctrl_rdat_q;

    // Two-flop synchronizer for the asynchronous row inputs
    always_ff @(posedge clk) begin : p_row_sync
        if (!resetn) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= row_n;
            row_sync_q <= row_meta_q;
        end
    end

    // Key currently being processed and its debounce decision
    logic        in_proc_c;
    logic [1:0]  proc_row_c;
    logic [3:0]  key_idx_c;
    logic [3:0]  key_cnt_inc_c;
    logic        key_diff_c;
    logic        push_c;
    logic [4:0]  push_data_c;

    always_comb begin
        in_proc_c  = 1'b0;
        proc_row_c = 2'd0;
        case (state_q)
            ST_PROC0: begin in_proc_c = 1'b1; proc_row_c = 2'd0; end
            ST_PROC1: begin in_proc_c = 1'b1; proc_row_c = 2'd1; end
            ST_PROC2: begin in_proc_c = 1'b1; proc_row_c = 2'd2; end
            ST_PROC3: begin in_proc_c = 1'b1; proc_row_c = 2'd3; end
            default:  ;
        endcase
        key_idx_c     = {proc_row_c, col_q};
        key_cnt_inc_c = deb_cnt_q[key_idx_c] + 4'd1;
        key_diff_c    = sample_q[proc_row_c] != deb_state_q[key_idx_c];
        push_c        = in_proc_c && key_diff_c && (key_cnt_inc_c == 4'(DEBOUNCE_SCANS));
        push_data_c   = {~deb_state_q[key_idx_c], key_idx_c};
    end

    // Column scan sequencer and per-key debounce state
    always_ff @(posedge clk) begin : p_scan
        if (!resetn) begin
            state_q      <= ST_SETTLE;
            settle_cnt_q <= '0;
            col_q        <= 2'd0;
            col_n_q      <= 4'b1110;
            sample_q     <= 4'd0;
            deb_state_q  <= 16'd0;
            for (int i = 0; i < 16; i++) deb_cnt_q[i] <= 4'd0;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (settle_cnt_q == SCW'(SETTLE_CLKS - 1)) begin
                        settle_cnt_q <= '0;
                        state_q      <= ST_SAMPLE;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + SCW'(1);
                    end
                end
                ST_SAMPLE: begin
                    sample_q <= ~row_sync_q;
                    state_q  <= ST_PROC0;
                end
                ST_PROC0: state_q <= ST_PROC1;
                ST_PROC1: state_q <= ST_PROC2;
                ST_PROC2: state_q <= ST_PROC3;
                ST_PROC3: begin
                    state_q <= ST_SETTLE;
                    col_q   <= col_q + 2'd1;
                    col_n_q <= ~(4'b0001 << (col_q + 2'd1));
                end
                default:  state_q <= ST_SETTLE;
            endcase
            if (in_proc_c) begin
                if (!key_diff_c) begin
                    deb_cnt_q[key_idx_c] <= 4'd0;
                end else if (push_c) begin
                    deb_state_q[key_idx_c] <= ~deb_state_q[key_idx_c];
                    deb_cnt_q[key_idx_c]   <= 4'd0;
                end else begin
                    deb_cnt_q[key_idx_c] <= key_cnt_inc_c;
                end
            end
        end
    end

    // Bus request decode; a request is ignored while the previous completes
    logic        req_c;
    logic        is_wr_c;
    logic        is_rd_c;
    logic [1:0]  sel_c;
    logic        evt_valid_c;
    logic        pop_c;
    logic        flush_c;
    logic        ovf_clr_c;
    logic        push_ok_c;
    logic        ovf_set_c;
    logic [31:0] rdat_c;

    always_comb begin
        req_c       = (|ctrl_wr || ctrl_rd) && !ctrl_done_q;
        is_wr_c     = req_c && |ctrl_wr;
        is_rd_c     = req_c && !(|ctrl_wr) && ctrl_rd;
        sel_c       = ctrl_addr[3:2];
        evt_valid_c = fifo_count_q != 4'd0;
        pop_c       = is_rd_c && sel_c == 2'd0 && evt_valid_c;
        flush_c     = is_wr_c && sel_c == 2'd1 && ctrl_wdat[1];
        ovf_clr_c   = is_wr_c && sel_c == 2'd1 && ctrl_wdat[0];
        // A pop in the same cycle frees the slot for a push into a full FIFO
        push_ok_c   = push_c && (fifo_count_q != 4'(FIFO_DEPTH) || pop_c);
        ovf_set_c   = push_c && !push_ok_c && !flush_c;
        rdat_c      = 32'd0;
        if (is_rd_c) begin
            case (sel_c)
                2'd0: rdat_c = {evt_valid_c, ovf_q, 10'd0, fifo_count_q, 11'd0,
                                evt_valid_c ? fifo_mem_q[rd_ptr_q] : 5'd0};
                2'd1: rdat_c = {16'd0, deb_state_q};
                default: rdat_c = 32'd0;
            endcase
        end
    end

    // Event FIFO storage (contents are qualified by the count)
    always_ff @(posedge clk) begin : p_fifo_mem
        if (push_ok_c) fifo_mem_q[wr_ptr_q] <= push_data_c;
    end

    // FIFO pointers, overflow flag and bus response
    always_ff @(posedge clk) begin : p_bus
        if (!resetn) begin
            wr_ptr_q     <= 3'd0;
            rd_ptr_q     <= 3'd0;
            fifo_count_q <= 4'd0;
            ovf_q        <= 1'b0;
            ctrl_done_q  <= 1'b0;
            ctrl_rdat_q  <= 32'd0;
        end else begin
            ctrl_done_q <= req_c;
            ctrl_rdat_q <= rdat_c;
            if (flush_c) begin
                wr_ptr_q     <= 3'd0;
                rd_ptr_q     <= 3'd0;
                fifo_count_q <= 4'd0;
            end else begin
                if (push_ok_c) wr_ptr_q <= wr_ptr_q + 3'd1;
                if (pop_c)     rd_ptr_q <= rd_ptr_q + 3'd1;
                fifo_count_q <= fifo_count_q + 4'(push_ok_c) - 4'(pop_c);
            end
            if (ovf_set_c)      ovf_q <= 1'b1;
            else if (ovf_clr_c) ovf_q <= 1'b0;
        end
    end

endmodule
